// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster timing bundle between the VGA timing generator
//                (master) and the pixel pipeline / renderer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW  = 10,
    parameter int FCW = 8
);
    logic           pix_en;
    logic [CW-1:0]  hcount;
    logic [CW-1:0]  vcount;
    logic           h_sync;
    logic           v_sync;
    logic           video_on;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_cnt;

    // Timing generator side: consumes the pixel enable, drives the raster.
    modport master (
        input  pix_en,
        output hcount, vcount, h_sync, v_sync, video_on,
               line_start, frame_start, frame_cnt
    );

    // Consumer side: supplies the pixel enable, observes the raster.
    modport slave (
        output pix_en,
        input  hcount, vcount, h_sync, v_sync, video_on,
               line_start, frame_start, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. Pixel/line
//                counters, polarity-selectable syncs, video-active flag and
//                one-clock line/frame start strobes. All outputs registered
//                and decoded from next-state counts (zero skew).
//                Optional completed-frame counter: VGA_TIMING_FRAME_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FCW      = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_gen_if.master bus
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_H_LAST     = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          c_H_ACT_LVL  = 1'(H_POL);
    localparam logic          c_V_ACT_LVL  = 1'(V_POL);

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_video_next;

    assign w_h_wrap = bus.pix_en && (r_hcount == c_H_LAST);
    assign w_v_wrap = w_h_wrap && (r_vcount == c_V_LAST);

    // Next-state counts; everything registered below is decoded from these so
    // the syncs and video flag line up with the counters they describe.
    always_comb begin
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (bus.pix_en) begin
            w_h_next = w_h_wrap ? '0 : r_hcount + CW'(1);
        end
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_vcount + CW'(1);
        end
    end

    assign w_hs_on      = (w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST);
    assign w_vs_on      = (w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST);
    assign w_video_next = (w_h_next < c_H_ACT) && (w_v_next < c_V_ACT);

    // Raster state and registered decodes; strobes fire only on a real wrap,
    // so the reset-release cycle is never strobed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_h_sync      <= ~c_H_ACT_LVL;
            r_v_sync      <= ~c_V_ACT_LVL;
            r_video_on    <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_h_sync      <= w_hs_on ? c_H_ACT_LVL : ~c_H_ACT_LVL;
            r_v_sync      <= w_vs_on ? c_V_ACT_LVL : ~c_V_ACT_LVL;
            r_video_on    <= w_video_next;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign bus.hcount      = r_hcount;
    assign bus.vcount      = r_vcount;
    assign bus.h_sync      = r_h_sync;
    assign bus.v_sync      = r_v_sync;
    assign bus.video_on    = r_video_on;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] r_frame_cnt;

    // Completed-frame counter, stepping on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + FCW'(1);
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`else
    assign bus.frame_cnt = {FCW{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Instance A uses the
//                default 640x480 timing, instance B a 4x3 raster with
//                active-high syncs and a 2-bit frame counter. Expected
//                outputs come from the raster position implied by the number
//                of enabled pixel clocks since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10), .FCW(8)) if_a ();
    vga_timing_gen_if #(.CW(4),  .FCW(2)) if_b ();

    vga_timing_gen u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .FCW(2)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    typedef struct packed {
        int h; int v; int hs; int vs; int von; int ls; int fs; int fc;
    } exp_t;

    // Position n pixel clocks into the raster; en is whether the last edge advanced.
    function automatic exp_t model(int n, bit en, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp,
                                   int hpol, int vpol, int fcw);
        exp_t e;
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int fr = n / (ht * vt);
        e.h   = n % ht;
        e.v   = (n / ht) % vt;
        e.hs  = (e.h >= ha + hfp && e.h < ha + hfp + hsw) ? hpol : 1 - hpol;
        e.vs  = (e.v >= va + vfp && e.v < va + vfp + vsw) ? vpol : 1 - vpol;
        e.von = (e.h < ha && e.v < va) ? 1 : 0;
        e.ls  = (en && n > 0 && e.h == 0) ? 1 : 0;
        e.fs  = (en && n > 0 && e.h == 0 && e.v == 0) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc  = fr % (1 << fcw);
`else
        e.fc  = 0 * fr;
`endif
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Enabled-pixel counts since reset for each instance.
    int na = 0;
    int nb = 0;
    bit ena_q = 1'b0;
    bit enb_q = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            na <= 0; nb <= 0; ena_q <= 1'b0; enb_q <= 1'b0;
        end else begin
            ena_q <= if_a.pix_en;
            enb_q <= if_b.pix_en;
            if (if_a.pix_en) na <= na + 1;
            if (if_b.pix_en) nb <= nb + 1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk) begin
            exp_t ea;
            exp_t eb;
            ea = model(na, ena_q, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8);
            eb = model(nb, enb_q, 4, 1, 1, 1, 3, 1, 1, 1, 1, 1, 2);
            check("A.hcount",      int'(if_a.hcount),      ea.h);
            check("A.vcount",      int'(if_a.vcount),      ea.v);
            check("A.h_sync",      int'(if_a.h_sync),      ea.hs);
            check("A.v_sync",      int'(if_a.v_sync),      ea.vs);
            check("A.video_on",    int'(if_a.video_on),    ea.von);
            check("A.line_start",  int'(if_a.line_start),  ea.ls);
            check("A.frame_start", int'(if_a.frame_start), ea.fs);
            check("A.frame_cnt",   int'(if_a.frame_cnt),   ea.fc);
            check("B.hcount",      int'(if_b.hcount),      eb.h);
            check("B.vcount",      int'(if_b.vcount),      eb.v);
            check("B.h_sync",      int'(if_b.h_sync),      eb.hs);
            check("B.v_sync",      int'(if_b.v_sync),      eb.vs);
            check("B.video_on",    int'(if_b.video_on),    eb.von);
            check("B.line_start",  int'(if_b.line_start),  eb.ls);
            check("B.frame_start", int'(if_b.frame_start), eb.fs);
            check("B.frame_cnt",   int'(if_b.frame_cnt),   eb.fc);
        end
    end

    initial begin
        int fc_b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_b1 = 1;
`else
        fc_b1 = 0;
`endif
        if_a.pix_en = 1'b0;
        if_b.pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk = 1'b1;
        check("rst.A.hcount",     int'(if_a.hcount),     0);
        check("rst.A.h_sync",     int'(if_a.h_sync),     1);
        check("rst.A.video_on",   int'(if_a.video_on),   1);
        check("rst.A.line_start", int'(if_a.line_start), 0);
        check("rst.B.h_sync",     int'(if_b.h_sync),     0);
        check("rst.B.v_sync",     int'(if_b.v_sync),     0);

        // Free-running pixel enable: one full line on A, many frames on B.
        @(negedge clk);
        rst = 1'b0;
        if_a.pix_en = 1'b1;
        if_b.pix_en = 1'b1;
        for (int k = 1; k <= 801; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)   check("lit.A.no_strobe_release", int'(if_a.line_start), 0);
            if (k == 639) check("lit.A.video_on_639",  int'(if_a.video_on), 1);
            if (k == 640) check("lit.A.video_on_640",  int'(if_a.video_on), 0);
            if (k == 655) check("lit.A.h_sync_655",    int'(if_a.h_sync),   1);
            if (k == 656) check("lit.A.h_sync_656",    int'(if_a.h_sync),   0);
            if (k == 751) check("lit.A.h_sync_751",    int'(if_a.h_sync),   0);
            if (k == 752) check("lit.A.h_sync_752",    int'(if_a.h_sync),   1);
            if (k == 799) check("lit.A.hcount_799",    int'(if_a.hcount),   799);
            if (k == 800) begin
                check("lit.A.hcount_wrap",  int'(if_a.hcount),     0);
                check("lit.A.vcount_1",     int'(if_a.vcount),     1);
                check("lit.A.line_start",   int'(if_a.line_start), 1);
            end
            if (k == 801) check("lit.A.line_start_1clk", int'(if_a.line_start), 0);
            if (k == 4)   check("lit.B.h_sync_h4",   int'(if_b.h_sync), 0);
            if (k == 5)   check("lit.B.h_sync_h5",   int'(if_b.h_sync), 1);
            if (k == 28)  check("lit.B.v_sync_v4",   int'(if_b.v_sync), 1);
            if (k == 41)  check("lit.B.frame_start_41", int'(if_b.frame_start), 0);
            if (k == 42) begin
                check("lit.B.frame_start_42", int'(if_b.frame_start), 1);
                check("lit.B.line_start_42",  int'(if_b.line_start),  1);
                check("lit.B.frame_cnt_42",   int'(if_b.frame_cnt),   fc_b1);
            end
        end

        // Randomised pixel enables.
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if_a.pix_en = 1'($urandom_range(0, 1));
            if_b.pix_en = 1'($urandom_range(0, 1));
        end

        // Divide-by-2 enable.
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if_a.pix_en = ~if_a.pix_en;
            if_b.pix_en = ~if_a.pix_en;
        end

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst.A.hcount",      int'(if_a.hcount),      0);
        check("arst.A.vcount",      int'(if_a.vcount),      0);
        check("arst.A.h_sync",      int'(if_a.h_sync),      1);
        check("arst.A.video_on",    int'(if_a.video_on),    1);
        check("arst.A.frame_start", int'(if_a.frame_start), 0);
        check("arst.B.hcount",      int'(if_b.hcount),      0);
        check("arst.B.frame_cnt",   int'(if_b.frame_cnt),   0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if_a.pix_en = ($urandom_range(0, 3) != 0);
            if_b.pix_en = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
